// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared state type, frame constants and checksum for the UART command parser
// FRAME_LEN is 4 with CMD_CHECKSUM_EN defined, otherwise 3.
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_CHK  = 2'd3
  } state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

`ifdef CMD_CHECKSUM_EN
  localparam int FRAME_LEN = 4;
`else
  localparam int FRAME_LEN = 3;
`endif

  function automatic logic [7:0] checksum(input logic [7:0] addr, input logic [7:0] data);
    return addr + data;
  endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// rtl/uart_cmd_timeout.sv - inter-byte idle timer for the UART command parser
// expire is asserted in the last allowed idle cycle unless clear arrives in that same cycle.
module uart_cmd_timeout #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] timer_q, timer_d;

  assign expire = run && !clear && (timer_q == LAST);

  always_comb begin
    timer_d = timer_q + TW'(1);
    if (clear || !run || expire) begin
      timer_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - decodes [SYNC, ADDR, DATA(, CHK)] byte frames into register-write strobes
// CMD_CHECKSUM_EN adds the checksum byte and its compare; without it frame_err comes only from timeout.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter int         CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             wr_en,
  output logic [7:0]       wr_addr,
  output logic [7:0]       wr_data,
  output logic             frame_err,
  output logic             busy,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] err_count
);

  state_t           state_q, state_d;
  logic [7:0]       addr_q, addr_d;
  logic             wr_en_q, wr_en_d;
  logic [7:0]       wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             frame_err_q, frame_err_d;
  logic [CNT_W-1:0] frame_count_q, frame_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             expire;
`ifdef CMD_CHECKSUM_EN
  logic [7:0]       data_q, data_d;
`endif

  uart_cmd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clear (rx_valid),
    .run   (state_q != S_IDLE),
    .expire(expire)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    frame_err_d   = 1'b0;
    frame_count_d = frame_count_q;
    err_count_d   = err_count_q;
`ifdef CMD_CHECKSUM_EN
    data_d        = data_q;
`endif

    if (rx_valid) begin
      case (state_q)
        S_IDLE: begin
          if (rx_data == SYNC_BYTE) begin
            state_d = S_ADDR;
          end
        end
        // A second SYNC here is a legal address, not a restart.
        S_ADDR: begin
          addr_d  = rx_data;
          state_d = S_DATA;
        end
        S_DATA: begin
`ifdef CMD_CHECKSUM_EN
          data_d  = rx_data;
          state_d = S_CHK;
`else
          state_d   = S_IDLE;
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = rx_data;
`endif
        end
        default: begin
          state_d = S_IDLE;
`ifdef CMD_CHECKSUM_EN
          if (rx_data == checksum(addr_q, data_q)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = data_q;
          end else begin
            frame_err_d = 1'b1;
          end
`endif
        end
      endcase
    end else if (expire) begin
      state_d     = S_IDLE;
      frame_err_d = 1'b1;
    end

    if (wr_en_d) begin
      frame_count_d = frame_count_q + CNT_W'(1);
    end
    if (frame_err_d && (err_count_q != {CNT_W{1'b1}})) begin
      err_count_d = err_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      frame_err_q   <= 1'b0;
      frame_count_q <= '0;
      err_count_q   <= '0;
`ifdef CMD_CHECKSUM_EN
      data_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      frame_err_q   <= frame_err_d;
      frame_count_q <= frame_count_d;
      err_count_q   <= err_count_d;
`ifdef CMD_CHECKSUM_EN
      data_q        <= data_d;
`endif
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign frame_err   = frame_err_q;
  assign busy        = (state_q != S_IDLE);
  assign frame_count = frame_count_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - directed self-checking bench for uart_cmd_parser
// Honours CMD_CHECKSUM_EN to match the RTL build.
module tb_uart_cmd_parser;

  localparam int TIMEOUT = 50;
  localparam int CW      = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          wr_en;
  logic [7:0]    wr_addr;
  logic [7:0]    wr_data;
  logic          frame_err;
  logic          busy;
  logic [CW-1:0] frame_count;
  logic [CW-1:0] err_count;

  int checks = 0;
  int failures = 0;
  int wr_pulses = 0;
  int err_pulses = 0;
  int both_high = 0;
  logic [CW-1:0] exp_frames = '0;
  logic [CW-1:0] exp_errs = '0;

  uart_cmd_parser #(
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(TIMEOUT),
    .CNT_W         (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_err  (frame_err),
    .busy       (busy),
    .frame_count(frame_count),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en === 1'b1) wr_pulses++;
    if (frame_err === 1'b1) err_pulses++;
    if (wr_en === 1'b1 && frame_err === 1'b1) both_high++;
  end

  // Each call occupies exactly one clock edge; the bench sits 1 time unit after posedge between calls.
  task automatic drive(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] s;
    s = a + d;
    drive(1'b1, 8'hA5);
    drive(1'b1, a);
    drive(1'b1, d);
`ifdef CMD_CHECKSUM_EN
    drive(1'b1, s);
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    exp_frames = '0;
    exp_errs   = '0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if ({wr_addr, wr_data} !== 16'h0000) begin failures++; $display("FAIL reset_wr_bus got=%h exp=0000", {wr_addr, wr_data}); end
    checks++; if ({frame_count, err_count} !== '0) begin failures++; $display("FAIL reset_counts got=%h/%h exp=0/0", frame_count, err_count); end
  endtask

  task automatic test_basic_frame();
    int w0, e0;
    w0 = wr_pulses; e0 = err_pulses;
    send_frame(8'h03, 8'h5A);
    exp_frames++;
    checks++; if (wr_en !== 1'b1) begin failures++; $display("FAIL basic_wr_en got=%b exp=1", wr_en); end
    checks++; if (wr_addr !== 8'h03) begin failures++; $display("FAIL basic_wr_addr got=%h exp=03", wr_addr); end
    checks++; if (wr_data !== 8'h5A) begin failures++; $display("FAIL basic_wr_data got=%h exp=5a", wr_data); end
    checks++; if (frame_count !== exp_frames) begin failures++; $display("FAIL basic_frame_count got=%0d exp=%0d", frame_count, exp_frames); end
    idle(1);
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL basic_wr_en_pulse got=%b exp=0", wr_en); end
    checks++; if (wr_addr !== 8'h03) begin failures++; $display("FAIL basic_addr_hold got=%h exp=03", wr_addr); end
    checks++; if (wr_pulses - w0 !== 1) begin failures++; $display("FAIL basic_wr_pulses got=%0d exp=1", wr_pulses - w0); end
    checks++; if (err_pulses - e0 !== 0) begin failures++; $display("FAIL basic_err_pulses got=%0d exp=0", err_pulses - e0); end
  endtask

  task automatic test_leading_garbage();
    int w0;
    w0 = wr_pulses;
    drive(1'b1, 8'h00);
    drive(1'b1, 8'hFF);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL garbage_busy got=%b exp=0", busy); end
    send_frame(8'h01, 8'h02);
    exp_frames++;
    checks++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 8'h01, 8'h02}) begin failures++; $display("FAIL garbage_write got=%b/%h/%h exp=1/01/02", wr_en, wr_addr, wr_data); end
    idle(1);
    checks++; if (wr_pulses - w0 !== 1) begin failures++; $display("FAIL garbage_wr_pulses got=%0d exp=1", wr_pulses - w0); end
    checks++; if (err_count !== exp_errs) begin failures++; $display("FAIL garbage_err_count got=%0d exp=%0d", err_count, exp_errs); end
    checks++; if (frame_count !== exp_frames) begin failures++; $display("FAIL garbage_frame_count got=%0d exp=%0d", frame_count, exp_frames); end
  endtask

`ifdef CMD_CHECKSUM_EN
  task automatic test_bad_checksum();
    drive(1'b1, 8'hA5);
    drive(1'b1, 8'h10);
    drive(1'b1, 8'h20);
    drive(1'b1, 8'h31);
    exp_errs++;
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL chk_wr_en got=%b exp=0", wr_en); end
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL chk_frame_err got=%b exp=1", frame_err); end
    checks++; if (err_count !== exp_errs) begin failures++; $display("FAIL chk_err_count got=%0d exp=%0d", err_count, exp_errs); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL chk_busy got=%b exp=0", busy); end
    send_frame(8'h11, 8'h22);
    exp_frames++;
    checks++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 8'h11, 8'h22}) begin failures++; $display("FAIL chk_recover got=%b/%h/%h exp=1/11/22", wr_en, wr_addr, wr_data); end
  endtask
`endif

  task automatic test_timeout();
    int w0, e0;
    w0 = wr_pulses; e0 = err_pulses;
    drive(1'b1, 8'hA5);
    drive(1'b1, 8'h07);
    idle(TIMEOUT - 1);
    checks++; if ({frame_err, busy} !== 2'b01) begin failures++; $display("FAIL tmo_before got=%b%b exp=01", frame_err, busy); end
    idle(1);
    exp_errs++;
    checks++; if ({frame_err, busy} !== 2'b10) begin failures++; $display("FAIL tmo_expiry got=%b%b exp=10", frame_err, busy); end
    checks++; if (err_count !== exp_errs) begin failures++; $display("FAIL tmo_err_count got=%0d exp=%0d", err_count, exp_errs); end
    idle(1);
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL tmo_pulse got=%b exp=0", frame_err); end
    checks++; if (wr_pulses - w0 !== 0) begin failures++; $display("FAIL tmo_no_write got=%0d exp=0", wr_pulses - w0); end
    checks++; if (err_pulses - e0 !== 1) begin failures++; $display("FAIL tmo_err_pulses got=%0d exp=1", err_pulses - e0); end
  endtask

  task automatic test_timeout_edge();
    int e0;
    logic [7:0] s;
    e0 = err_pulses;
    s = 8'h07 + 8'h5A;
    drive(1'b1, 8'hA5);
    drive(1'b1, 8'h07);
    idle(TIMEOUT - 1);
    drive(1'b1, 8'h5A);
`ifdef CMD_CHECKSUM_EN
    drive(1'b1, s);
`endif
    exp_frames++;
    checks++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 8'h07, 8'h5A}) begin failures++; $display("FAIL edge_write got=%b/%h/%h exp=1/07/5a", wr_en, wr_addr, wr_data); end
    idle(2);
    checks++; if (err_pulses - e0 !== 0) begin failures++; $display("FAIL edge_no_err got=%0d exp=0", err_pulses - e0); end
    checks++; if (err_count !== exp_errs) begin failures++; $display("FAIL edge_err_count got=%0d exp=%0d", err_count, exp_errs); end
  endtask

  task automatic test_reset_midframe();
    int w0, e0;
    w0 = wr_pulses; e0 = err_pulses;
    drive(1'b1, 8'hA5);
    drive(1'b1, 8'h07);
    reset = 1'b1;
    drive(1'b1, 8'h33);
    reset = 1'b0;
    exp_frames = '0;
    exp_errs   = '0;
    checks++; if ({wr_en, frame_err, busy} !== 3'b000) begin failures++; $display("FAIL rst_mid_flags got=%b%b%b exp=000", wr_en, frame_err, busy); end
    checks++; if ({wr_addr, wr_data, frame_count, err_count} !== '0) begin failures++; $display("FAIL rst_mid_outputs got=%h exp=0", {wr_addr, wr_data, frame_count, err_count}); end
    idle(TIMEOUT + 5);
    checks++; if (wr_pulses - w0 + err_pulses - e0 !== 0) begin failures++; $display("FAIL rst_mid_pulses got=%0d exp=0", wr_pulses - w0 + err_pulses - e0); end
    send_frame(8'h44, 8'h55);
    exp_frames++;
    checks++; if ({wr_en, wr_addr, wr_data, frame_count} !== {1'b1, 8'h44, 8'h55, exp_frames}) begin failures++; $display("FAIL rst_mid_frame got=%b/%h/%h/%0d exp=1/44/55/%0d", wr_en, wr_addr, wr_data, frame_count, exp_frames); end
  endtask

  task automatic test_back_to_back();
    int w0, bad;
    logic [7:0] a, d;
    do_reset();
    w0 = wr_pulses;
    bad = 0;
    for (int i = 0; i < (1 << CW) + 1; i++) begin
      a = 8'(i * 3);
      d = 8'(i) ^ 8'h5C;
      send_frame(a, d);
      exp_frames++;
      if ({wr_en, wr_addr, wr_data} !== {1'b1, a, d}) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL b2b_writes got=%0d bad frames exp=0", bad); end
    idle(1);
    checks++; if (wr_pulses - w0 !== (1 << CW) + 1) begin failures++; $display("FAIL b2b_wr_pulses got=%0d exp=%0d", wr_pulses - w0, (1 << CW) + 1); end
    checks++; if (frame_count !== 4'd1) begin failures++; $display("FAIL b2b_wrap got=%0d exp=1", frame_count); end
  endtask

  task automatic test_err_saturate();
    int e0;
    e0 = err_pulses;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 8'hA5);
      idle(TIMEOUT + 1);
      if (exp_errs != 4'hF) exp_errs++;
      if (i == 14) begin
        checks++; if (err_count !== 4'd15) begin failures++; $display("FAIL sat_reach got=%0d exp=15", err_count); end
      end
    end
    checks++; if (err_count !== exp_errs) begin failures++; $display("FAIL sat_hold got=%0d exp=%0d", err_count, exp_errs); end
    checks++; if (err_pulses - e0 !== 17) begin failures++; $display("FAIL sat_pulses got=%0d exp=17", err_pulses - e0); end
    checks++; if (both_high !== 0) begin failures++; $display("FAIL wr_err_overlap got=%0d exp=0", both_high); end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic_frame();
    test_leading_garbage();
`ifdef CMD_CHECKSUM_EN
    test_bad_checksum();
`endif
    test_timeout();
    test_timeout_edge();
    test_reset_midframe();
    test_back_to_back();
    test_err_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
